// File: rtl/eic_nested_if.sv
// Register port and CPU interrupt handshake of the nested interrupt controller.
// Master drives addresses, writes and ack/EOI; slave returns read data and the request.
interface eic_nested_if;
  logic [4:0]  read_addr;
  logic [31:0] read_data;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic        irq_req;
  logic [7:0]  irq_vector;
  logic [3:0]  irq_prio;
  logic        irq_ack;
  logic        irq_eoi;

  modport master (
    output read_addr, write_addr, write_data, write_enable, irq_ack, irq_eoi,
    input  read_data, irq_req, irq_vector, irq_prio
  );

  modport slave (
    input  read_addr, write_addr, write_data, write_enable, irq_ack, irq_eoi,
    output read_data, irq_req, irq_vector, irq_prio
  );
endinterface

// File: rtl/eic_nested.sv
// Nested external interrupt controller: sense/mask/priority per channel, registered arbitration,
// ack/EOI in-service stack. Request lags pending by one edge; ack with a full stack only sets OVF.
module eic_nested #(
  parameter int NUM_CH     = 64,
  parameter int PRIO_W     = 3,
  parameter int NEST_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] signal,
  eic_nested_if.slave       bus
);
  localparam logic [63:0] CH_MASK = (NUM_CH == 64) ? '1 : ((64'd1 << NUM_CH) - 64'd1);

  function automatic logic [127:0] sense_wmask();
    logic [127:0] m = '0;
    for (int i = 0; i < NUM_CH; i++) m[2*i +: 2] = 2'b11;
    return m;
  endfunction

  function automatic logic [255:0] prio_wmask();
    logic [255:0] m = '0;
    for (int i = 0; i < NUM_CH; i++) m[4*i +: 4] = 4'((1 << PRIO_W) - 1);
    return m;
  endfunction

  localparam logic [127:0] SENSE_WMASK = sense_wmask();
  localparam logic [255:0] PRIO_WMASK  = prio_wmask();

  logic         en_q;
  logic [3:0]   thresh_q;
  logic         ovf_q;
  logic [63:0]  mask_q;
  logic [63:0]  pend_q;
  logic [63:0]  sig_prev_q;
  logic         primed_q;
  logic [127:0] sense_q;
  logic [255:0] prio_q;
  logic [7:0]   stk_vec_q  [8];
  logic [3:0]   stk_prio_q [8];
  logic [3:0]   depth_q;
  logic         req_q;
  logic [7:0]   vec_q;
  logic [3:0]   prio_out_q;

  logic [63:0] sig, rise, fall, pset, pclr, pend_d;
  logic [2:0]  top_idx, rd_pidx, wr_pidx;
  logic [7:0]  top_vec, win_vec;
  logic [3:0]  top_prio, floor_prio, win_prio, depth_pop;
  logic [6:0]  win_ch;
  logic        pop, push, ovf_set;
  logic [31:0] rd;

  assign sig      = 64'(signal);
  assign rise     = sig & ~sig_prev_q & {64{primed_q}};
  assign fall     = ~sig & sig_prev_q & {64{primed_q}};
  assign top_idx  = 3'(depth_q - 4'd1);
  assign top_vec  = (depth_q == 4'd0) ? 8'd0 : stk_vec_q[top_idx];
  assign top_prio = (depth_q == 4'd0) ? 4'd0 : stk_prio_q[top_idx];
  assign rd_pidx  = 3'(bus.read_addr - 5'd12);
  assign wr_pidx  = 3'(bus.write_addr - 5'd12);

  // EOI pops before ack pushes, so a simultaneous pair replaces the top entry.
  assign pop       = bus.irq_eoi && (depth_q != 4'd0);
  assign depth_pop = depth_q - {3'd0, pop};
  assign push      = bus.irq_ack && req_q && (depth_pop < 4'(NEST_DEPTH));
  assign ovf_set   = bus.irq_ack && req_q && !push;

  always_comb begin
    pset = '0;
    pclr = '0;
    for (int i = 0; i < 64; i++) begin
      case (sense_q[2*i +: 2])
        2'b00:   pset[i] = sig[i];
        2'b01:   pset[i] = rise[i];
        2'b10:   pset[i] = fall[i];
        default: pset[i] = rise[i] | fall[i];
      endcase
    end
    if (bus.write_enable && (bus.write_addr == 5'd4 || bus.write_addr == 5'd5))
      pset[{bus.write_addr[0], 5'd0} +: 32] = pset[{bus.write_addr[0], 5'd0} +: 32] | bus.write_data;
    if (bus.write_enable && (bus.write_addr == 5'd6 || bus.write_addr == 5'd7))
      pclr[{bus.write_addr[0], 5'd0} +: 32] = bus.write_data;
    if (push)
      pclr[6'(vec_q - 8'd1)] = 1'b1;
    pend_d = ((pend_q & ~pclr) | pset) & CH_MASK;
  end

  // Strict compare keeps the lowest channel on priority ties.
  always_comb begin
    floor_prio = (thresh_q > top_prio) ? thresh_q : top_prio;
    win_prio   = '0;
    win_ch     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_q && pend_q[i] && mask_q[i] && (prio_q[4*i +: 4] > floor_prio) &&
          (prio_q[4*i +: 4] > win_prio)) begin
        win_prio = prio_q[4*i +: 4];
        win_ch   = 7'(i);
      end
    end
    win_vec = (win_prio != 4'd0) ? ({1'b0, win_ch} + 8'd1) : 8'd0;
  end

  always_comb begin
    rd = '0;
    case (bus.read_addr)
      5'd0:                      rd = {24'd0, thresh_q, 3'd0, en_q};
      5'd1:                      rd = {15'd0, ovf_q, depth_q, top_prio, top_vec};
      5'd2, 5'd3:                rd = mask_q[{bus.read_addr[0], 5'd0} +: 32];
      5'd4, 5'd5:                rd = pend_q[{bus.read_addr[0], 5'd0} +: 32];
      5'd8, 5'd9, 5'd10, 5'd11:  rd = sense_q[{bus.read_addr[1:0], 5'd0} +: 32];
      5'd12, 5'd13, 5'd14, 5'd15,
      5'd16, 5'd17, 5'd18, 5'd19: rd = prio_q[{rd_pidx, 5'd0} +: 32];
      5'd20, 5'd21:              rd = sig[{bus.read_addr[0], 5'd0} +: 32];
      default:                   rd = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      en_q       <= 1'b0;
      thresh_q   <= '0;
      ovf_q      <= 1'b0;
      mask_q     <= '0;
      pend_q     <= '0;
      sig_prev_q <= '0;
      primed_q   <= 1'b0;
      sense_q    <= '0;
      prio_q     <= '0;
      depth_q    <= '0;
      req_q      <= 1'b0;
      vec_q      <= '0;
      prio_out_q <= '0;
      for (int i = 0; i < 8; i++) begin
        stk_vec_q[i]  <= '0;
        stk_prio_q[i] <= '0;
      end
    end else begin
      sig_prev_q <= sig;
      primed_q   <= 1'b1;
      pend_q     <= pend_d;
      if (bus.write_enable) begin
        case (bus.write_addr)
          5'd0: begin
            en_q     <= bus.write_data[0];
            thresh_q <= bus.write_data[7:4];
          end
          5'd2, 5'd3:
            mask_q[{bus.write_addr[0], 5'd0} +: 32] <=
              bus.write_data & CH_MASK[{bus.write_addr[0], 5'd0} +: 32];
          5'd8, 5'd9, 5'd10, 5'd11:
            sense_q[{bus.write_addr[1:0], 5'd0} +: 32] <=
              bus.write_data & SENSE_WMASK[{bus.write_addr[1:0], 5'd0} +: 32];
          5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19:
            prio_q[{wr_pidx, 5'd0} +: 32] <= bus.write_data & PRIO_WMASK[{wr_pidx, 5'd0} +: 32];
          default: ;
        endcase
      end
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (bus.write_enable && bus.write_addr == 5'd1 && bus.write_data[16])
        ovf_q <= 1'b0;
      if (push) begin
        stk_vec_q[3'(depth_pop)]  <= vec_q;
        stk_prio_q[3'(depth_pop)] <= prio_out_q;
      end
      depth_q <= depth_pop + {3'd0, push};
      if (push) begin
        req_q      <= 1'b0;
        vec_q      <= '0;
        prio_out_q <= '0;
      end else begin
        req_q      <= (win_prio != 4'd0);
        vec_q      <= win_vec;
        prio_out_q <= win_prio;
      end
    end
  end

  assign bus.read_data  = rd;
  assign bus.irq_req    = req_q;
  assign bus.irq_vector = vec_q;
  assign bus.irq_prio   = prio_out_q;
endmodule

// File: tb/tb_eic_nested.sv
// Bench for eic_nested: directed scenarios with fixed expectations, then random traffic
// compared cycle by cycle against a queue-based behavioural model.
module tb_eic_nested;
  localparam int NUM_CH = 64;
  localparam int PRIO_W = 3;
  localparam int NEST_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [63:0] sig = '0;
  int          checks = 0;
  int          errors = 0;

  eic_nested_if bus();

  eic_nested #(.NUM_CH(NUM_CH), .PRIO_W(PRIO_W), .NEST_DEPTH(NEST_DEPTH)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .signal(sig),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: per-channel arrays and an in-service queue.
  bit m_en, m_ovf, m_primed, m_req;
  int m_thresh, m_vec, m_pr;
  bit m_mask[64], m_pend[64], m_prev[64];
  int m_sense[64], m_prio[64];
  int m_svec[$], m_sprio[$];

  always @(posedge CLK) begin : model
    bit ev_set[64], ev_clr[64];
    bit acc, rise, fall;
    int best, bch, flr, a;
    logic [31:0] d;
    if (RESET) begin
      m_en = 0; m_ovf = 0; m_primed = 0; m_req = 0; m_thresh = 0; m_vec = 0; m_pr = 0;
      for (int i = 0; i < 64; i++) begin
        m_mask[i] = 0; m_pend[i] = 0; m_prev[i] = 0; m_sense[i] = 0; m_prio[i] = 0;
      end
      m_svec.delete();
      m_sprio.delete();
    end else begin
      flr = m_thresh;
      if (m_sprio.size() > 0 && m_sprio[$] > flr) flr = m_sprio[$];
      best = 0; bch = 0;
      for (int i = 0; i < NUM_CH; i++)
        if (m_en && m_pend[i] && m_mask[i] && m_prio[i] > flr && m_prio[i] > best) begin
          best = m_prio[i]; bch = i;
        end
      for (int i = 0; i < 64; i++) begin
        rise = m_primed && sig[i] && !m_prev[i];
        fall = m_primed && !sig[i] && m_prev[i];
        ev_clr[i] = 0;
        case (m_sense[i])
          0: ev_set[i] = sig[i];
          1: ev_set[i] = rise;
          2: ev_set[i] = fall;
          default: ev_set[i] = rise || fall;
        endcase
      end
      if (bus.write_enable) begin
        a = int'(bus.write_addr);
        d = bus.write_data;
        if (a == 0) begin m_en = d[0]; m_thresh = int'(d[7:4]); end
        else if (a == 1) begin if (d[16]) m_ovf = 0; end
        else if (a == 2 || a == 3) for (int j = 0; j < 32; j++) m_mask[(a-2)*32+j] = d[j];
        else if (a == 4 || a == 5) for (int j = 0; j < 32; j++) begin if (d[j]) ev_set[(a-4)*32+j] = 1; end
        else if (a == 6 || a == 7) for (int j = 0; j < 32; j++) begin if (d[j]) ev_clr[(a-6)*32+j] = 1; end
        else if (a >= 8 && a <= 11) for (int j = 0; j < 16; j++) m_sense[(a-8)*16+j] = int'(d[2*j +: 2]);
        else if (a >= 12 && a <= 19)
          for (int j = 0; j < 8; j++) m_prio[(a-12)*8+j] = int'(d[4*j +: 4]) % (1 << PRIO_W);
      end
      if (bus.irq_eoi && m_svec.size() > 0) begin
        void'(m_svec.pop_back());
        void'(m_sprio.pop_back());
      end
      acc = 0;
      if (bus.irq_ack && m_req) begin
        if (m_svec.size() < NEST_DEPTH) begin
          acc = 1;
          m_svec.push_back(m_vec);
          m_sprio.push_back(m_pr);
          ev_clr[m_vec-1] = 1;
        end else m_ovf = 1;
      end
      for (int i = 0; i < 64; i++) m_pend[i] = (m_pend[i] && !ev_clr[i]) || ev_set[i];
      m_req = !acc && best > 0;
      m_vec = (!acc && best > 0) ? bch + 1 : 0;
      m_pr  = acc ? 0 : best;
      for (int i = 0; i < 64; i++) m_prev[i] = sig[i];
      m_primed = 1;
    end
  end

  function automatic logic [31:0] m_read(int a);
    logic [31:0] r = '0;
    if (a == 0) r = {24'd0, 4'(m_thresh), 3'd0, m_en};
    else if (a == 1)
      r = {15'd0, m_ovf, 4'(m_svec.size()),
           4'((m_sprio.size() > 0) ? m_sprio[$] : 0), 8'((m_svec.size() > 0) ? m_svec[$] : 0)};
    else if (a == 2 || a == 3) for (int j = 0; j < 32; j++) r[j] = m_mask[(a-2)*32+j];
    else if (a == 4 || a == 5) for (int j = 0; j < 32; j++) r[j] = m_pend[(a-4)*32+j];
    else if (a >= 8 && a <= 11) for (int j = 0; j < 16; j++) r[2*j +: 2] = 2'(m_sense[(a-8)*16+j]);
    else if (a >= 12 && a <= 19) for (int j = 0; j < 8; j++) r[4*j +: 4] = 4'(m_prio[(a-12)*8+j]);
    else if (a == 20 || a == 21) for (int j = 0; j < 32; j++) r[j] = sig[(a-20)*32+j];
    return r;
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.write_addr = a; bus.write_data = d; bus.write_enable = 1'b1;
    @(negedge CLK);
    bus.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.read_addr = a;
    #1;
    d = bus.read_data;
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1'b1;
    @(negedge CLK);
    bus.irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.irq_eoi = 1'b1;
    @(negedge CLK);
    bus.irq_eoi = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; sig = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.irq_req, bus.irq_vector, bus.irq_prio} !== 13'd0) begin
      errors++; $display("FAIL reset_irq: got %h required 0", {bus.irq_req, bus.irq_vector, bus.irq_prio});
    end
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), r);
      checks++;
      if (r !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h required 0", a, r); end
    end
    RESET = 1'b0;
  endtask

  task automatic test_edge();
    logic [31:0] r;
    do_reset();
    wr(5'd8, 32'h0000_0400);
    wr(5'd12, 32'h0030_0000);
    wr(5'd2, 32'h0000_0020);
    wr(5'd0, 32'h0000_0001);
    sig[5] = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL edge_early: got req %b required 0", bus.irq_req); end
    @(negedge CLK);
    checks++;
    if ({bus.irq_req, bus.irq_vector, bus.irq_prio} !== {1'b1, 8'd6, 4'd3}) begin
      errors++; $display("FAIL edge_req: got %b/%0d/%0d required 1/6/3", bus.irq_req, bus.irq_vector, bus.irq_prio);
    end
    pulse_ack();
    checks++;
    if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL edge_ack_req: got %b required 0", bus.irq_req); end
    rd(5'd4, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL edge_pend: got %h required 0", r); end
    rd(5'd1, r);
    checks++;
    if (r !== 32'h0000_1306) begin errors++; $display("FAIL edge_status: got %h required 00001306", r); end
    pulse_eoi();
    sig = '0;
  endtask

  task automatic test_tie();
    do_reset();
    wr(5'd12, 32'h0000_0200);
    wr(5'd13, 32'h0000_0020);
    wr(5'd2, 32'h0000_0204);
    wr(5'd0, 32'h0000_0001);
    wr(5'd4, 32'h0000_0204);
    @(negedge CLK);
    checks++;
    if ({bus.irq_req, bus.irq_vector, bus.irq_prio} !== {1'b1, 8'd3, 4'd2}) begin
      errors++; $display("FAIL tie_first: got %b/%0d/%0d required 1/3/2", bus.irq_req, bus.irq_vector, bus.irq_prio);
    end
    pulse_ack();
    @(negedge CLK);
    checks++;
    if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL tie_blocked: got req %b required 0", bus.irq_req); end
    pulse_eoi();
    @(negedge CLK);
    checks++;
    if ({bus.irq_req, bus.irq_vector, bus.irq_prio} !== {1'b1, 8'd10, 4'd2}) begin
      errors++; $display("FAIL tie_second: got %b/%0d/%0d required 1/10/2", bus.irq_req, bus.irq_vector, bus.irq_prio);
    end
  endtask

  task automatic test_nest();
    logic [31:0] r;
    do_reset();
    wr(5'd12, 32'h5000_1020);
    wr(5'd2, 32'h0000_008A);
    wr(5'd0, 32'h0000_0001);
    wr(5'd4, 32'h0000_0002);
    @(negedge CLK);
    checks++;
    if (bus.irq_vector !== 8'd2) begin errors++; $display("FAIL nest_outer: got vector %0d required 2", bus.irq_vector); end
    pulse_ack();
    wr(5'd4, 32'h0000_0088);
    @(negedge CLK);
    checks++;
    if ({bus.irq_req, bus.irq_vector, bus.irq_prio} !== {1'b1, 8'd8, 4'd5}) begin
      errors++; $display("FAIL nest_inner: got %b/%0d/%0d required 1/8/5", bus.irq_req, bus.irq_vector, bus.irq_prio);
    end
    pulse_ack();
    rd(5'd1, r);
    checks++;
    if (r !== 32'h0000_2508) begin errors++; $display("FAIL nest_status: got %h required 00002508", r); end
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL nest_low_d2: got req %b required 0", bus.irq_req); end
    pulse_eoi();
    repeat (2) @(negedge CLK);
    checks++;
    if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL nest_low_d1: got req %b required 0", bus.irq_req); end
    pulse_eoi();
    @(negedge CLK);
    checks++;
    if ({bus.irq_req, bus.irq_vector, bus.irq_prio} !== {1'b1, 8'd4, 4'd1}) begin
      errors++; $display("FAIL nest_low: got %b/%0d/%0d required 1/4/1", bus.irq_req, bus.irq_vector, bus.irq_prio);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    do_reset();
    wr(5'd13, 32'h0543_2100);
    wr(5'd2, 32'h0000_7C00);
    wr(5'd0, 32'h0000_0001);
    for (int k = 0; k < 5; k++) begin
      wr(5'd4, 32'd1 << (10 + k));
      @(negedge CLK);
      checks++;
      if ({bus.irq_req, bus.irq_vector, bus.irq_prio} !== {1'b1, 8'(11 + k), 4'(k + 1)}) begin
        errors++; $display("FAIL ovf_req%0d: got %b/%0d/%0d required 1/%0d/%0d", k,
                           bus.irq_req, bus.irq_vector, bus.irq_prio, 11 + k, k + 1);
      end
      pulse_ack();
    end
    rd(5'd1, r);
    checks++;
    if (r !== 32'h0001_440E) begin errors++; $display("FAIL ovf_status: got %h required 0001440e", r); end
    rd(5'd4, r);
    checks++;
    if (r !== 32'h0000_4000) begin errors++; $display("FAIL ovf_pend: got %h required 00004000", r); end
    wr(5'd1, 32'h0001_0000);
    rd(5'd1, r);
    checks++;
    if (r !== 32'h0000_440E) begin errors++; $display("FAIL ovf_clear: got %h required 0000440e", r); end
  endtask

  task automatic test_level();
    logic [31:0] r;
    do_reset();
    wr(5'd12, 32'h0000_0001);
    wr(5'd2, 32'h0000_0001);
    wr(5'd0, 32'h0000_0001);
    sig[0] = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({bus.irq_req, bus.irq_vector, bus.irq_prio} !== {1'b1, 8'd1, 4'd1}) begin
      errors++; $display("FAIL level_req: got %b/%0d/%0d required 1/1/1", bus.irq_req, bus.irq_vector, bus.irq_prio);
    end
    pulse_ack();
    rd(5'd4, r);
    checks++;
    if (bus.irq_req !== 1'b0 || r !== 32'h1) begin
      errors++; $display("FAIL level_ack: got req %b pend %h required 0 / 00000001", bus.irq_req, r);
    end
    pulse_eoi();
    @(negedge CLK);
    checks++;
    if ({bus.irq_req, bus.irq_vector} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL level_repend: got %b/%0d required 1/1", bus.irq_req, bus.irq_vector);
    end
    wr(5'd0, 32'h0000_0011);
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL level_thresh: got req %b required 0", bus.irq_req); end
    sig = '0;
  endtask

  task automatic test_collision();
    logic [31:0] r;
    do_reset();
    wr(5'd8, 32'h0000_0100);
    sig[4] = 1'b1;
    bus.write_addr = 5'd6; bus.write_data = 32'h10; bus.write_enable = 1'b1;
    @(negedge CLK);
    bus.write_enable = 1'b0;
    rd(5'd4, r);
    checks++;
    if (r !== 32'h10) begin errors++; $display("FAIL coll_pend: got %h required 00000010", r); end
    wr(5'd6, 32'h10);
    rd(5'd4, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL coll_pendc: got %h required 0", r); end
    wr(5'd12, 32'h0503_0000);
    wr(5'd2, 32'h0000_0050);
    wr(5'd0, 32'h0000_0001);
    wr(5'd4, 32'h0000_0010);
    @(negedge CLK);
    pulse_ack();
    wr(5'd4, 32'h0000_0040);
    @(negedge CLK);
    pulse_ack();
    wr(5'd5, 32'hFFFF_FFFF);
    rd(5'd1, r);
    checks++;
    if (r !== 32'h0000_2507) begin errors++; $display("FAIL coll_depth2: got %h required 00002507", r); end
    sig = '0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    rd(5'd1, r);
    checks++;
    if (r !== 32'h0 || bus.irq_req !== 1'b0) begin
      errors++; $display("FAIL coll_reset: got status %h req %b required 0/0", r, bus.irq_req);
    end
    rd(5'd4, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL coll_reset_pend_lo: got %h required 0", r); end
    rd(5'd5, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL coll_reset_pend_hi: got %h required 0", r); end
  endtask

  task automatic test_random();
    logic [31:0] r, d;
    logic [4:0]  a;
    int          ra;
    do_reset();
    for (int w = 8; w < 20; w++) wr(5'(w), $urandom);
    wr(5'd2, $urandom);
    wr(5'd3, $urandom);
    wr(5'd0, 32'h0000_0001);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      bus.write_enable = 1'b0; bus.irq_ack = 1'b0; bus.irq_eoi = 1'b0;
      checks++;
      if (bus.irq_req !== m_req || bus.irq_vector !== 8'(m_vec) || bus.irq_prio !== 4'(m_pr)) begin
        errors++; $display("FAIL rand_irq@%0d: got %b/%0d/%0d required %b/%0d/%0d", cyc,
                           bus.irq_req, bus.irq_vector, bus.irq_prio, m_req, m_vec, m_pr);
      end
      ra = $urandom_range(0, 31);
      rd(5'(ra), r);
      checks++;
      if (r !== m_read(ra)) begin
        errors++; $display("FAIL rand_read%0d@%0d: got %h required %h", ra, cyc, r, m_read(ra));
      end
      sig = sig ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      bus.irq_ack = (bus.irq_req && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 19) == 0);
      bus.irq_eoi = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        a = 5'($urandom_range(0, 21));
        d = $urandom;
        if (a == 5'd0) d[7:4] = 4'($urandom_range(0, 3));
        if (a == 5'd0 && $urandom_range(0, 4) != 0) d[0] = 1'b1;
        bus.write_addr = a; bus.write_data = d; bus.write_enable = 1'b1;
      end
    end
    @(negedge CLK);
    bus.write_enable = 1'b0; bus.irq_ack = 1'b0; bus.irq_eoi = 1'b0;
  endtask

  initial begin
    bus.read_addr = '0; bus.write_addr = '0; bus.write_data = '0;
    bus.write_enable = 1'b0; bus.irq_ack = 1'b0; bus.irq_eoi = 1'b0;
    test_reset();
    test_edge();
    test_tie();
    test_nest();
    test_overflow();
    test_level();
    test_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
